guess_controller: RTL and testbench
===================================

GUESS_CONTROLLER -- requirements
Module: guess_controller

Interface
REQ-001 SHALL provide parameter: HIST_DEPTH, default 8, number of stored past guesses (power of 2, 2..16).
REQ-002 SHALL provide ports (clock and reset first):
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_left  in  1  single-cycle pulse, pre-debounced: cursor left / older history.
- btn_right  in  1  single-cycle pulse: cursor right / newer history.
- btn_color  in  1  single-cycle pulse: advance colour at cursor.
- btn_submit  in  1  single-cycle pulse: commit current guess.
- btn_mode  in  1  single-cycle pulse: toggle GUESS/HISTORY.
- blink_enable  out  1  1 in GUESS, 0 in HISTORY.
- blink_led  out  2  cursor position 0..3.
- guess_rgb0..guess_rgb3  out  3 each  current guess colours.
- history_rgb0..history_rgb3  out  3 each  colours of the viewed history entry.
- guess_valid  out  1  one-cycle pulse on commit.
- guess_word  out  12  committed guess {rgb3,rgb2,rgb1,rgb0}; valid while guess_valid=1.
- history_count  out  5  stored entries, saturates at HIST_DEPTH.

Function
REQ-003 SHALL implement a two-state FSM: GUESS, HISTORY; btn_mode toggles the state.
REQ-004 SHALL register all outputs; an effect SHALL appear on outputs exactly one cycle after the input pulse.
REQ-005 SHALL process at most one button per cycle, priority btn_mode > btn_submit > btn_color > btn_left > btn_right; lower-priority pulses in the same cycle SHALL be dropped.
REQ-006 SHALL drive blink_enable=1 in GUESS and 0 in HISTORY.
REQ-007 GUESS, btn_left: blink_led decrements, 0 wraps to 3; btn_right: increments, 3 wraps to 0.
REQ-008 GUESS, btn_color: colour at blink_led advances 001->010->...->111->001; 000 is never produced.
REQ-009 GUESS, btn_submit: guess written to the history buffer at write pointer; pointer advances modulo HIST_DEPTH; history_count increments, saturating at HIST_DEPTH; guess_valid=1 with guess_word for one cycle; blink_led returns to 0; guess colours are retained.
REQ-010 SHALL overwrite the oldest entry when history is full (circular buffer).
REQ-011 HISTORY: view index v, 0 = most recent; btn_left increments v up to history_count-1 (saturating); btn_right decrements v down to 0 (saturating).
REQ-012 SHALL ignore btn_color and btn_submit in HISTORY; guess and cursor SHALL be frozen.
REQ-013 Entry into HISTORY SHALL set v=0; exit to GUESS SHALL preserve guess and cursor.
REQ-014 history_rgb0..3 SHALL show entry v; with history_count=0 they SHALL be 000.
REQ-015 history_rgb outputs SHALL track v and buffer contents in both states.

Reset
REQ-016 On rst: state=GUESS, blink_enable=1, blink_led=0, guess_rgb0..3=001, history_rgb0..3=000, guess_valid=0, guess_word=0, history_count=0, write pointer=0, v=0.
REQ-017 Reset SHALL act immediately (asynchronously), including mid-operation and during a guess_valid pulse, and SHALL take priority over all buttons; buffer contents need not be cleared, but with history_count=0 they SHALL be unobservable.

Verification
REQ-018 Reset then 3x btn_color at cursor 0 -> guess_rgb0=100, others 001; 7 more -> guess_rgb0=100 again (wrap skips 000).
REQ-019 btn_left from blink_led=0 -> 3; btn_right from 3 -> 0.
REQ-020 Set guess {010,011,001,100}, btn_submit -> next cycle guess_valid=1, guess_word=12'b100_001_011_010, history_count=1, blink_led=0; guess_valid=0 on the following cycle.
REQ-021 Submit HIST_DEPTH+2 distinct guesses, enter HISTORY, press btn_left repeatedly -> history_count=8, v saturates at 7, oldest shown is guess #3; btn_right beyond v=0 keeps newest.
REQ-022 btn_mode+btn_submit in the same cycle -> state toggles, no commit; in HISTORY, btn_color -> guess unchanged.
REQ-023 Assert rst during the guess_valid pulse -> guess_valid=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/guess_controller.sv
// Colour-guess entry controller: cursor/colour editing of a 4-slot guess plus a
// circular history of committed guesses, browsable in a separate HISTORY mode.
module guess_controller #(
    parameter int HIST_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_color,
    input  logic        btn_submit,
    input  logic        btn_mode,
    output logic        blink_enable,
    output logic [1:0]  blink_led,
    output logic [2:0]  guess_rgb0,
    output logic [2:0]  guess_rgb1,
    output logic [2:0]  guess_rgb2,
    output logic [2:0]  guess_rgb3,
    output logic [2:0]  history_rgb0,
    output logic [2:0]  history_rgb1,
    output logic [2:0]  history_rgb2,
    output logic [2:0]  history_rgb3,
    output logic        guess_valid,
    output logic [11:0] guess_word,
    output logic [4:0]  history_count
);
    localparam int PTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

    typedef enum logic {GUESS = 1'b0, HISTORY = 1'b1} state_t;

    state_t                 state, state_next;
    logic [1:0]             cursor, cursor_next;
    logic [3:0][2:0]        guess, guess_next;
    logic [11:0]            mem [HIST_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, wr_ptr_next;
    logic [PTR_W-1:0]       view, view_next;
    logic [4:0]             count, count_next;
    logic                   valid_next;
    logic [11:0]            word_next;
    logic                   write_en;
    logic [PTR_W-1:0]       rd_idx;
    logic [11:0]            rd_word;
    logic [11:0]            hist, hist_next;

    function automatic logic [2:0] next_colour(input logic [2:0] c);
        return (c == 3'd7) ? 3'd1 : c + 3'd1;
    endfunction

    always_comb begin
        state_next  = state;
        cursor_next = cursor;
        guess_next  = guess;
        wr_ptr_next = wr_ptr;
        view_next   = view;
        count_next  = count;
        valid_next  = 1'b0;
        word_next   = guess_word;
        write_en    = 1'b0;

        if (btn_mode) begin
            state_next = (state == GUESS) ? HISTORY : GUESS;
            if (state == GUESS)
                view_next = '0;
        end else if (state == GUESS) begin
            if (btn_submit) begin
                write_en    = 1'b1;
                word_next   = guess;
                valid_next  = 1'b1;
                wr_ptr_next = wr_ptr + PTR_W'(1);
                cursor_next = 2'd0;
                if (count < 5'(HIST_DEPTH))
                    count_next = count + 5'd1;
            end else if (btn_color) begin
                guess_next[cursor] = next_colour(guess[cursor]);
            end else if (btn_left) begin
                cursor_next = cursor - 2'd1;
            end else if (btn_right) begin
                cursor_next = cursor + 2'd1;
            end
        end else begin
            // submit/colour are swallowed in HISTORY but still mask left/right
            if (!(btn_submit || btn_color)) begin
                if (btn_left) begin
                    if (5'(view) + 5'd1 < count)
                        view_next = view + PTR_W'(1);
                end else if (btn_right) begin
                    if (view != '0)
                        view_next = view - PTR_W'(1);
                end
            end
        end

        // Look up the entry that will be in view after this edge, bypassing the
        // buffer when that entry is being written in the same cycle.
        rd_idx  = wr_ptr_next - PTR_W'(1) - view_next;
        rd_word = (write_en && rd_idx == wr_ptr) ? word_next : mem[rd_idx];
        hist_next = (count_next == 5'd0) ? 12'd0 : rd_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= GUESS;
            blink_enable <= 1'b1;
            cursor       <= 2'd0;
            guess        <= {4{3'd1}};
            wr_ptr       <= '0;
            view         <= '0;
            count        <= 5'd0;
            guess_valid  <= 1'b0;
            guess_word   <= 12'd0;
            hist         <= 12'd0;
        end else begin
            state        <= state_next;
            blink_enable <= (state_next == GUESS);
            cursor       <= cursor_next;
            guess        <= guess_next;
            wr_ptr       <= wr_ptr_next;
            view         <= view_next;
            count        <= count_next;
            guess_valid  <= valid_next;
            guess_word   <= word_next;
            hist         <= hist_next;
        end
    end

    // Buffer contents are left uncleared by reset; count=0 hides them.
    always_ff @(posedge clk) begin
        if (write_en)
            mem[wr_ptr] <= word_next;
    end

    assign blink_led     = cursor;
    assign guess_rgb0    = guess[0];
    assign guess_rgb1    = guess[1];
    assign guess_rgb2    = guess[2];
    assign guess_rgb3    = guess[3];
    assign history_rgb0  = hist[2:0];
    assign history_rgb1  = hist[5:3];
    assign history_rgb2  = hist[8:6];
    assign history_rgb3  = hist[11:9];
    assign history_count = count;

endmodule

// File: tb/tb_guess_controller.sv
// Bench for guess_controller: directed scenarios plus randomized button traffic
// compared every cycle against a queue-based behavioural model.
module tb_guess_controller;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_left, btn_right, btn_color, btn_submit, btn_mode;
    logic        blink_enable;
    logic [1:0]  blink_led;
    logic [2:0]  guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3;
    logic [2:0]  history_rgb0, history_rgb1, history_rgb2, history_rgb3;
    logic        guess_valid;
    logic [11:0] guess_word;
    logic [4:0]  history_count;

    guess_controller #(.HIST_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .btn_left(btn_left), .btn_right(btn_right), .btn_color(btn_color),
        .btn_submit(btn_submit), .btn_mode(btn_mode),
        .blink_enable(blink_enable), .blink_led(blink_led),
        .guess_rgb0(guess_rgb0), .guess_rgb1(guess_rgb1),
        .guess_rgb2(guess_rgb2), .guess_rgb3(guess_rgb3),
        .history_rgb0(history_rgb0), .history_rgb1(history_rgb1),
        .history_rgb2(history_rgb2), .history_rgb3(history_rgb3),
        .guess_valid(guess_valid), .guess_word(guess_word),
        .history_count(history_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model: newest guess at the front of a queue.
    bit  m_hist_mode;
    int  m_cursor;
    int  m_g[4];
    int  m_q[$];
    int  m_v;
    bit  m_valid;
    int  m_word;
    int  submitted[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pack_guess();
        return (m_g[3] << 9) | (m_g[2] << 6) | (m_g[1] << 3) | m_g[0];
    endfunction

    function automatic void model_reset();
        m_hist_mode = 0;
        m_cursor    = 0;
        foreach (m_g[i]) m_g[i] = 1;
        m_q.delete();
        m_v     = 0;
        m_valid = 0;
        m_word  = 0;
    endfunction

    // b = {mode, submit, color, left, right}
    function automatic void model_step(input logic [4:0] b);
        m_valid = 0;
        if (b[4]) begin
            if (!m_hist_mode) m_v = 0;
            m_hist_mode = !m_hist_mode;
        end else if (!m_hist_mode) begin
            if (b[3]) begin
                m_word = pack_guess();
                m_q.push_front(m_word);
                if (m_q.size() > D) void'(m_q.pop_back());
                submitted.push_back(m_word);
                m_valid  = 1;
                m_cursor = 0;
            end else if (b[2]) begin
                m_g[m_cursor] = (m_g[m_cursor] == 7) ? 1 : m_g[m_cursor] + 1;
            end else if (b[1]) begin
                m_cursor = (m_cursor + 3) % 4;
            end else if (b[0]) begin
                m_cursor = (m_cursor + 1) % 4;
            end
        end else if (!(b[3] || b[2])) begin
            if (b[1]) begin
                if (m_v < m_q.size() - 1) m_v++;
            end else if (b[0]) begin
                if (m_v > 0) m_v--;
            end
        end
    endfunction

    task automatic compare_all(input string ctx);
        int h;
        h = (m_q.size() == 0) ? 0 : m_q[m_v];
        check({ctx, ".blink_enable"}, int'(blink_enable), int'(!m_hist_mode));
        check({ctx, ".blink_led"}, int'(blink_led), m_cursor);
        check({ctx, ".guess_rgb"},
              int'({guess_rgb3, guess_rgb2, guess_rgb1, guess_rgb0}), pack_guess());
        check({ctx, ".history_rgb"},
              int'({history_rgb3, history_rgb2, history_rgb1, history_rgb0}), h);
        check({ctx, ".guess_valid"}, int'(guess_valid), int'(m_valid));
        if (m_valid)
            check({ctx, ".guess_word"}, int'(guess_word), m_word);
        check({ctx, ".history_count"}, int'(history_count), m_q.size());
    endtask

    task automatic press(input logic [4:0] b, input string ctx);
        {btn_mode, btn_submit, btn_color, btn_left, btn_right} = b;
        @(posedge clk);
        #1;
        {btn_mode, btn_submit, btn_color, btn_left, btn_right} = '0;
        model_step(b);
        compare_all(ctx);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        compare_all("reset");
        rst = 1'b0;
    endtask

    localparam logic [4:0] B_MODE = 5'b10000, B_SUB = 5'b01000, B_COL = 5'b00100,
                           B_LEFT = 5'b00010, B_RIGHT = 5'b00001, B_NONE = 5'b00000;

    initial begin
        {btn_mode, btn_submit, btn_color, btn_left, btn_right} = '0;
        model_reset();
        do_reset();

        // Colour cycling at cursor 0, wrap skips 000
        for (int i = 0; i < 3; i++) press(B_COL, "col3");
        check("col3.rgb0", int'(guess_rgb0), 3'b100);
        check("col3.rgb1", int'(guess_rgb1), 3'b001);
        for (int i = 0; i < 7; i++) press(B_COL, "col7");
        check("col10.rgb0", int'(guess_rgb0), 3'b100);

        // Cursor wrap both ways
        press(B_LEFT, "wrapL");
        check("wrapL.led", int'(blink_led), 3);
        press(B_RIGHT, "wrapR");
        check("wrapR.led", int'(blink_led), 0);

        // Build {010,011,001,100} and commit
        do_reset();
        press(B_COL, "bld");
        press(B_RIGHT, "bld"); press(B_COL, "bld"); press(B_COL, "bld");
        press(B_RIGHT, "bld"); press(B_RIGHT, "bld");
        for (int i = 0; i < 3; i++) press(B_COL, "bld");
        press(B_SUB, "commit");
        check("commit.valid", int'(guess_valid), 1);
        check("commit.word", int'(guess_word), 12'b100_001_011_010);
        check("commit.count", int'(history_count), 1);
        check("commit.led", int'(blink_led), 0);
        press(B_NONE, "after");
        check("after.valid", int'(guess_valid), 0);

        // Overfill history by two and browse it
        do_reset();
        submitted.delete();
        for (int i = 0; i < D + 2; i++) begin
            press(B_COL, "fill");
            if (i >= 5) begin
                press(B_RIGHT, "fill");
                press(B_COL, "fill");
            end
            press(B_SUB, "fill");
        end
        press(B_MODE, "hist");
        for (int i = 0; i < D + 1; i++) press(B_LEFT, "histL");
        check("hist.count", int'(history_count), D);
        check("hist.oldest",
              int'({history_rgb3, history_rgb2, history_rgb1, history_rgb0}), submitted[2]);
        for (int i = 0; i < D + 1; i++) press(B_RIGHT, "histR");
        check("hist.newest",
              int'({history_rgb3, history_rgb2, history_rgb1, history_rgb0}), submitted[D + 1]);

        // Mode beats submit; colour ignored in HISTORY
        press(B_MODE | B_SUB, "modesub");
        check("modesub.en", int'(blink_enable), 1);
        check("modesub.valid", int'(guess_valid), 0);
        press(B_MODE, "tohist");
        press(B_COL, "histcol");
        press(B_MODE, "toguess");

        // Asynchronous reset during the guess_valid pulse
        press(B_SUB, "prerst");
        check("prerst.valid", int'(guess_valid), 1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all("asyncrst");
        check("asyncrst.word", int'(guess_word), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] b;
            b[4] = ($urandom_range(0, 9) == 0);
            b[3] = ($urandom_range(0, 5) == 0);
            b[2] = ($urandom_range(0, 2) == 0);
            b[1] = ($urandom_range(0, 2) == 0);
            b[0] = ($urandom_range(0, 2) == 0);
            press(b, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
